uart_tx_feeder: RTL and testbench

Buffers multi-byte words from the pipeline's debug/readout logic and feeds them byte by byte into the UART transmitter. It sits directly upstream of the transmitter:
- drives `tx_start` and `data_in`;
- waits for `tx_done_tick` before presenting the next byte.

Words are queued in a small FIFO so the producer never has to track UART pacing.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_feeder_if.sv | 18 +
 rtl/word_fifo.sv | 52 +++++
 rtl/uart_tx_feeder.sv | 63 ++++++
 tb/tb_uart_tx_feeder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, byte width and default sizing for the UART feeder
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_FIFO_AW = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } state_t;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer push port and transmitter handshake of the UART feeder
//   wr_en/wr_data/full/empty/busy : word producer side
//   tx_start/data_out/tx_done_tick : UART transmitter side
//   master = producer/transmitter environment, slave = feeder
interface uart_tx_feeder_if import uart_pkg::*; #(
  parameter int WORD_BYTES = DEF_WORD_BYTES
);
  logic                         wr_en;
  logic [BYTE_W*WORD_BYTES-1:0] wr_data;
  logic                         full;
  logic                         empty;
  logic                         busy;
  logic                         tx_start;
  logic [BYTE_W-1:0]            data_out;
  logic                         tx_done_tick;
  modport master (output wr_en, wr_data, tx_done_tick, input full, empty, busy, tx_start, data_out);
  modport slave  (input wr_en, wr_data, tx_done_tick, output full, empty, busy, tx_start, data_out);
endinterface

// File: rtl/word_fifo.sv
// word_fifo: small word FIFO with registered pointers and count
//   wr_en/wr_data : push, ignored while full
//   rd_en/rd_data : pop, rd_data shows the head word combinationally
//   full/empty    : derived from the registered count
module word_fifo #(
  parameter int W  = 32,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  // count never exceeds DEPTH, so its top bit alone flags full
  assign full    = count_q[AW];
  assign empty   = count_q == '0;
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + (AW+1)'(1)
             : (pop && !push) ? count_q - (AW+1)'(1)
             : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: queues multi-byte words and feeds them LSB-first into a UART transmitter
//   clk/reset : single clock, synchronous active-high reset
//   bus       : push port (wr_en, wr_data, full, empty, busy) and
//               transmitter handshake (tx_start, data_out, tx_done_tick)
module uart_tx_feeder import uart_pkg::*; #(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int FIFO_AW    = DEF_FIFO_AW
) (
  input logic            clk,
  input logic            reset,
  uart_tx_feeder_if.slave bus
);
  localparam int W = BYTE_W * WORD_BYTES;
  state_t            state_q, state_d;
  logic [W-1:0]      shift_q, shift_d, head;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              pop, last, adv;
  word_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (bus.full),
    .empty   (bus.empty)
  );
  assign pop  = state_q == IDLE && !bus.empty;
  assign last = cnt_q == 3'(WORD_BYTES - 1);
  // ticks outside WAIT (e.g. a byte still draining after reset) are ignored
  assign adv  = state_q == WAIT && bus.tx_done_tick && !last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end
  always_comb begin
    state_d = pop ? START
            : state_q == START ? WAIT
            : state_q == WAIT ? (bus.tx_done_tick ? (last ? IDLE : START) : WAIT)
            : IDLE;
  end
  // data_out is loaded together with the shift register so it is already valid in START
  always_comb begin
    shift_d    = pop ? head : adv ? shift_q >> BYTE_W : shift_q;
    cnt_d      = pop ? 3'd0 : adv ? cnt_q + 3'd1 : cnt_q;
    data_out_d = (pop || adv) ? shift_d[BYTE_W-1:0] : data_out_q;
  end
  always_comb begin
    bus.tx_start = state_q == START;
    bus.busy     = state_q != IDLE || !bus.empty;
    bus.data_out = data_out_q;
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed vectors and corner-case sequences for uart_tx_feeder
module tb_uart_tx_feeder;
  import uart_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  uart_tx_feeder_if #(.WORD_BYTES(4)) bus();
  uart_tx_feeder #(.WORD_BYTES(4), .FIFO_AW(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic tick_man = 0, tick_auto = 0, auto_en = 0;
  int tick_dly = 20;
  assign bus.tx_done_tick = tick_man | tick_auto;
  int cyc = 0, total = 0, bad = 0, idle_cyc = 0;
  logic [7:0] byte_q[$];
  int start_q[$], tick_q[$];
  logic [31:0] exp_w[$];
  typedef struct {
    logic [31:0] word;
    logic [31:0] seq;
    int          dly;
  } vec_t;
  vec_t vecs[5];
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (bus.tx_start) begin
      byte_q.push_back(bus.data_out);
      start_q.push_back(cyc);
    end
    if (bus.tx_done_tick) tick_q.push_back(cyc);
  end
  initial forever begin
    @(negedge clk);
    tick_auto = 0;
    if (auto_en && bus.tx_start) begin
      repeat (tick_dly) @(negedge clk);
      if (auto_en) tick_auto = 1;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_q();
    byte_q.delete();
    start_q.delete();
    tick_q.delete();
  endtask
  task automatic push(input logic [31:0] w, output int pc);
    @(negedge clk);
    bus.wr_en = 1;
    bus.wr_data = w;
    pc = cyc;
    @(negedge clk);
    bus.wr_en = 0;
  endtask
  task automatic burst();
    foreach (exp_w[i]) begin
      @(negedge clk);
      bus.wr_en = 1;
      bus.wr_data = exp_w[i];
    end
    @(negedge clk);
    bus.wr_en = 0;
  endtask
  task automatic tick_pulse();
    @(negedge clk);
    tick_man = 1;
    @(negedge clk);
    tick_man = 0;
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy && k < budget);
    idle_cyc = cyc;
    chk("idle_wait", 64'(bus.busy), 0);
  endtask
  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("start_wait", 64'(start_q.size() >= n), 1);
  endtask
  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 64'(byte_q.size()), 64'(exp_w.size() * 4));
    for (int j = 0; j < exp_w.size() * 4 && j < byte_q.size(); j++)
      chk($sformatf("%s_b%0d", tag, j), 64'(byte_q[j]), 64'(exp_w[j/4][8*(j%4) +: 8]));
  endtask
  initial begin
    int pc, m;
    vec_t v;
    bus.wr_en = 0;
    bus.wr_data = '0;
    vecs[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1, 20};
    vecs[1] = '{32'h00000000, 32'h00000000, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3};
    vecs[3] = '{32'h80000001, 32'h01000080, 2};
    vecs[4] = '{32'hDEADBEEF, 32'hEFBEADDE, 7};
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_tx_start", 64'(bus.tx_start), 0);
    chk("rst_data_out", 64'(bus.data_out), 0);
    chk("rst_full", 64'(bus.full), 0);
    chk("rst_empty", 64'(bus.empty), 1);
    chk("rst_busy", 64'(bus.busy), 0);
    foreach (vecs[i]) begin
      v = vecs[i];
      clear_q();
      tick_dly = v.dly;
      auto_en = 1;
      push(v.word, pc);
      wait_idle(400);
      chk($sformatf("v%0d_starts", i), 64'(start_q.size()), 4);
      for (int b = 0; b < 4 && b < byte_q.size(); b++)
        chk($sformatf("v%0d_byte%0d", i, b), 64'(byte_q[b]), 64'(v.seq[31-8*b -: 8]));
      if (start_q.size() == 4 && tick_q.size() == 4) begin
        chk($sformatf("v%0d_first_lat", i), 64'(start_q[0] - pc), 2);
        for (int b = 0; b < 3; b++)
          chk($sformatf("v%0d_gap%0d", i, b), 64'(start_q[b+1] - tick_q[b]), 1);
        chk($sformatf("v%0d_busy_fall", i), 64'(idle_cyc - tick_q[3]), 1);
      end
    end
    // overflow: one word parked in WAIT, four queued, fifth dropped
    clear_q();
    auto_en = 0;
    push(32'hCAFEF00D, pc);
    wait_starts(1, 20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 3) chk("ovf_full_before_4th", 64'(bus.full), 0);
      if (i == 4) chk("ovf_full_after_4th", 64'(bus.full), 1);
      bus.wr_en = 1;
      bus.wr_data = 32'(i);
    end
    @(negedge clk);
    bus.wr_en = 0;
    chk("ovf_full_hold", 64'(bus.full), 1);
    tick_dly = 2;
    auto_en = 1;
    tick_pulse();
    wait_idle(600);
    exp_w = '{32'hCAFEF00D, 32'h0, 32'h1, 32'h2, 32'h3};
    check_stream("ovf");
    chk("ovf_empty", 64'(bus.empty), 1);
    // push on a full FIFO in the cycle IDLE pops
    clear_q();
    auto_en = 0;
    push(32'h0F0E0D0C, pc);
    wait_starts(1, 20);
    exp_w = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};
    burst();
    chk("pp_full", 64'(bus.full), 1);
    for (int i = 2; i <= 4; i++) begin
      tick_pulse();
      wait_starts(i, 20);
    end
    @(negedge clk);
    tick_man = 1;
    @(negedge clk);
    tick_man = 0;
    chk("pp_full_at_pop", 64'(bus.full), 1);
    bus.wr_en = 1;
    bus.wr_data = 32'hEEEEEEEE;
    @(negedge clk);
    chk("pp_full_after_pop", 64'(bus.full), 0);
    bus.wr_data = 32'h53525150;
    @(negedge clk);
    bus.wr_en = 0;
    chk("pp_full_after_repush", 64'(bus.full), 1);
    tick_dly = 1;
    auto_en = 1;
    tick_man = 1;
    @(negedge clk);
    tick_man = 0;
    wait_idle(600);
    exp_w = '{32'h0F0E0D0C, 32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140, 32'h53525150};
    check_stream("pp");
    // back-to-back words
    clear_q();
    tick_dly = 5;
    auto_en = 1;
    exp_w = '{32'h11223344, 32'h55667788};
    burst();
    wait_idle(400);
    check_stream("b2b");
    if (start_q.size() == 8 && tick_q.size() == 8)
      chk("b2b_word_gap", 64'(start_q[4] - tick_q[3]), 2);
    else
      chk("b2b_pulse_count", 64'(start_q.size()), 8);
    // stray ticks while idle: last byte sent was 8'h55
    clear_q();
    auto_en = 0;
    for (int i = 0; i < 3; i++) tick_pulse();
    repeat (3) @(negedge clk);
    chk("stray_no_start", 64'(start_q.size()), 0);
    chk("stray_data_out", 64'(bus.data_out), 64'h55);
    chk("stray_busy", 64'(bus.busy), 0);
    // reset mid-word with two words queued
    clear_q();
    exp_w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    burst();
    wait_starts(1, 20);
    tick_pulse();
    wait_starts(2, 20);
    chk("mid_byte1", 64'(byte_q[1]), 64'h22);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_tx_start", 64'(bus.tx_start), 0);
    chk("mid_rst_data_out", 64'(bus.data_out), 0);
    chk("mid_rst_full", 64'(bus.full), 0);
    chk("mid_rst_empty", 64'(bus.empty), 1);
    chk("mid_rst_busy", 64'(bus.busy), 0);
    tick_pulse();
    repeat (4) @(negedge clk);
    chk("mid_no_start", 64'(start_q.size()), 2);
    chk("mid_empty", 64'(bus.empty), 1);
    chk("mid_busy", 64'(bus.busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
